// File: rtl/rob_mc_if.sv
// Bus bundle for rob_mc: dispatch, writeback, commit and status signals.
// When ROB_PERF_EN is defined the performance counter outputs are included.
interface rob_mc_if #(
  parameter int unsigned SS        = 2,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned N_WB      = 3,
  parameter int unsigned PAYLOAD_W = 64,
  parameter int unsigned ID_W      = $clog2(DEPTH)
);
  logic [SS-1:0]                  disp_valid;
  logic [SS-1:0][PAYLOAD_W-1:0]   disp_payload;
  logic                           disp_ready;
  logic [SS-1:0][ID_W-1:0]        alloc_id;
  logic [N_WB-1:0]                wb_valid;
  logic [N_WB-1:0][ID_W-1:0]      wb_id;
  logic                           commit_stall;
  logic [SS-1:0]                  commit_valid;
  logic [SS-1:0][PAYLOAD_W-1:0]   commit_payload;
  logic [SS-1:0][ID_W-1:0]        commit_id;
  logic [SS-1:0][63:0]            commit_order;
  logic                           flush;
  logic [ID_W:0]                  count;
  logic                           full;
  logic                           empty;
`ifdef ROB_PERF_EN
  logic [31:0]                    perf_head_block;
  logic [31:0]                    perf_full_cycles;
  logic [SS:0][31:0]              perf_commit_hist;
`endif

  // Environment side: dispatch/rename, writeback channels and commit stage
  modport master (
`ifdef ROB_PERF_EN
    input  perf_head_block, perf_full_cycles, perf_commit_hist,
`endif
    output disp_valid, disp_payload, wb_valid, wb_id, commit_stall, flush,
    input  disp_ready, alloc_id, commit_valid, commit_payload, commit_id,
    input  commit_order, count, full, empty
  );

  // Reorder buffer side
  modport slave (
`ifdef ROB_PERF_EN
    output perf_head_block, perf_full_cycles, perf_commit_hist,
`endif
    input  disp_valid, disp_payload, wb_valid, wb_id, commit_stall, flush,
    output disp_ready, alloc_id, commit_valid, commit_payload, commit_id,
    output commit_order, count, full, empty
  );
endinterface

// File: rtl/rob_mc.sv
// rob_mc: multi-lane reorder buffer. Allocates up to SS entries per cycle,
// marks entries done from N_WB writeback channels and retires the longest
// ready in-order prefix (up to SS) per cycle with a running order counter.
// Optional macro ROB_PERF_EN adds saturating performance counters.
module rob_mc #(
  parameter int unsigned SS        = 2,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned N_WB      = 3,
  parameter int unsigned PAYLOAD_W = 64,
  parameter int unsigned ID_W      = $clog2(DEPTH)
) (
  input  logic    clk,
  input  logic    rst,
  rob_mc_if.slave bus
);
  localparam int unsigned     CNT_W     = ID_W + 1;
  localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(DEPTH - SS);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  logic [CNT_W-1:0]                head_q, head_d, tail_q, tail_d;
  logic [DEPTH-1:0]                valid_q, valid_d, done_q, done_d;
  logic [DEPTH-1:0][PAYLOAD_W-1:0] payload_q, payload_d;
  logic [63:0]                     order_q, order_d;

  logic [CNT_W-1:0]             count_c, n_c, k_c;
  logic                         disp_ready_c, disp_fire_c, full_c, empty_c;
  logic [SS-1:0]                commit_valid_c;
  logic [SS-1:0][ID_W-1:0]      commit_id_c, alloc_id_c;
  logic [SS-1:0][PAYLOAD_W-1:0] commit_payload_c;
  logic [SS-1:0][63:0]          commit_order_c;

  // Occupancy and dispatch acceptance from registered pointers only
  assign count_c      = tail_q - head_q;
  assign full_c       = (count_c == DEPTH_CNT);
  assign empty_c      = (count_c == '0);
  assign disp_ready_c = (count_c <= READY_MAX);
  assign disp_fire_c  = disp_ready_c && (|bus.disp_valid) && !bus.flush;

  // Id each dispatch lane receives, modulo DEPTH
  always_comb begin
    alloc_id_c = '0;
    for (int unsigned i = 0; i < SS; i++) begin
      alloc_id_c[i] = tail_q[ID_W-1:0] + ID_W'(i);
    end
  end

  // Longest ready in-order prefix starting at head
  always_comb begin
    logic [ID_W-1:0] idx;
    logic            run;
    commit_valid_c   = '0;
    commit_id_c      = '0;
    commit_payload_c = '0;
    commit_order_c   = '0;
    idx              = '0;
    run              = !bus.commit_stall && !bus.flush;
    for (int unsigned i = 0; i < SS; i++) begin
      idx = head_q[ID_W-1:0] + ID_W'(i);
      if (run && valid_q[idx] && done_q[idx]) begin
        commit_valid_c[i]   = 1'b1;
        commit_id_c[i]      = idx;
        commit_payload_c[i] = payload_q[idx];
        commit_order_c[i]   = order_q + 64'(i);
      end else begin
        run = 1'b0;
      end
    end
  end

  // Next state: writeback, retire, allocate; flush overrides all but order
  always_comb begin
    logic [ID_W-1:0] idx;
    head_d    = head_q;
    tail_d    = tail_q;
    valid_d   = valid_q;
    done_d    = done_q;
    payload_d = payload_q;
    order_d   = order_q;
    n_c       = '0;
    k_c       = '0;
    idx       = '0;
    for (int unsigned i = 0; i < SS; i++) begin
      n_c = n_c + CNT_W'(bus.disp_valid[i]);
      k_c = k_c + CNT_W'(commit_valid_c[i]);
    end
    for (int unsigned w = 0; w < N_WB; w++) begin
      if (bus.wb_valid[w] && valid_q[bus.wb_id[w]]) begin
        done_d[bus.wb_id[w]] = 1'b1;
      end
    end
    for (int unsigned i = 0; i < SS; i++) begin
      if (commit_valid_c[i]) begin
        idx          = head_q[ID_W-1:0] + ID_W'(i);
        valid_d[idx] = 1'b0;
        done_d[idx]  = 1'b0;
      end
    end
    if (disp_fire_c) begin
      for (int unsigned i = 0; i < SS; i++) begin
        if (bus.disp_valid[i]) begin
          idx            = tail_q[ID_W-1:0] + ID_W'(i);
          valid_d[idx]   = 1'b1;
          done_d[idx]    = 1'b0;
          payload_d[idx] = bus.disp_payload[i];
        end
      end
      tail_d = tail_q + n_c;
    end
    head_d  = head_q + k_c;
    order_d = order_q + 64'(k_c);
    if (bus.flush) begin
      head_d  = '0;
      tail_d  = '0;
      valid_d = '0;
      done_d  = '0;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q    <= '0;
      tail_q    <= '0;
      valid_q   <= '0;
      done_q    <= '0;
      payload_q <= '0;
      order_q   <= '0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
      payload_q <= payload_d;
      order_q   <= order_d;
    end
  end

  assign bus.disp_ready     = disp_ready_c;
  assign bus.alloc_id       = alloc_id_c;
  assign bus.commit_valid   = commit_valid_c;
  assign bus.commit_id      = commit_id_c;
  assign bus.commit_payload = commit_payload_c;
  assign bus.commit_order   = commit_order_c;
  assign bus.count          = count_c;
  assign bus.full           = full_c;
  assign bus.empty          = empty_c;

  // Dispatch lanes must form a contiguous run starting at lane 0
  logic disp_contig_c;
  assign disp_contig_c = ((bus.disp_valid & (bus.disp_valid + SS'(1))) == '0);
  assert property (@(posedge clk) disable iff (!rst) disp_contig_c);

`ifdef ROB_PERF_EN
  logic [31:0]       perf_head_block_q, perf_head_block_d;
  logic [31:0]       perf_full_q, perf_full_d;
  logic [SS:0][31:0] perf_hist_q, perf_hist_d;

  // Saturating event counters; only reset clears them
  always_comb begin
    perf_head_block_d = perf_head_block_q;
    perf_full_d       = perf_full_q;
    perf_hist_d       = perf_hist_q;
    if (!empty_c && !commit_valid_c[0] && !bus.commit_stall && (perf_head_block_q != '1)) begin
      perf_head_block_d = perf_head_block_q + 32'd1;
    end
    if (full_c && (perf_full_q != '1)) begin
      perf_full_d = perf_full_q + 32'd1;
    end
    for (int unsigned b = 0; b <= SS; b++) begin
      if ((k_c == CNT_W'(b)) && (perf_hist_q[b] != '1)) begin
        perf_hist_d[b] = perf_hist_q[b] + 32'd1;
      end
    end
  end

  // Performance counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_head_block_q <= '0;
      perf_full_q       <= '0;
      perf_hist_q       <= '0;
    end else begin
      perf_head_block_q <= perf_head_block_d;
      perf_full_q       <= perf_full_d;
      perf_hist_q       <= perf_hist_d;
    end
  end

  assign bus.perf_head_block  = perf_head_block_q;
  assign bus.perf_full_cycles = perf_full_q;
  assign bus.perf_commit_hist = perf_hist_q;
`endif
endmodule
